axis_gpio_event_stamper: RTL and testbench

// - Consumes the free-running GPIO word stream of the GPIO reader stage.
// - Detects configurable rising/falling edges on selected GPIO bits.
// - For each edge, emits one {timestamp, gpio word} beat on an AXI4-Stream master.
// - A small FIFO absorbs downstream backpressure; overflow is counted, never stalls the input.

---
 rtl/axis_event_fifo.sv | 72 +++++++
 rtl/axis_gpio_event_stamper.sv | 105 ++++++++++
 tb/tb_axis_gpio_event_stamper.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_event_fifo.sv
// Purpose : synchronous first-word-fall-through FIFO that holds stamped GPIO events.
// Latency : a write shows on rd_data/empty after 1 clock; a read frees its slot on the same edge.
// Backpressure: a write while full is accepted only if a read happens on the same edge, otherwise it is ignored.
// Ports   : aclk/aresetn clock and async active-low reset; wr_en/wr_data/full write side;
//           rd_en/rd_data/empty read side (rd_data valid while !empty); count = occupancy.
module axis_event_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

  // A read on the same edge frees the head slot, so a full FIFO can still take a write.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Idle output reads as zero so the stream data is clean whenever tvalid is low.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers/count.
  always_ff @(posedge aclk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/axis_gpio_event_stamper.sv
// Purpose : detects masked rising/falling edges on a GPIO word stream and emits {timestamp, word} beats.
// Latency : 2 clocks from the sampled input beat to m_axis_tvalid when the FIFO is empty.
// Backpressure: input is never stalled; events arriving at a full FIFO with no read are dropped and counted.
// Ports   : aclk/aresetn clock and async active-low reset; cfg_* enable and edge masks;
//           s_axis_* GPIO word input (no tready); m_axis_* event stream; sts_count FIFO
//           occupancy; sts_lost saturating dropped-event count.
module axis_gpio_event_stamper #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 16,
  parameter int LOST_WIDTH       = 16
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 cfg_enable,
  input  logic [AXIS_TDATA_WIDTH-1:0]          cfg_rise_mask,
  input  logic [AXIS_TDATA_WIDTH-1:0]          cfg_fall_mask,
  input  logic [AXIS_TDATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic [CNTR_WIDTH+AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]          sts_count,
  output logic [LOST_WIDTH-1:0]                sts_lost
);

  localparam int EW = CNTR_WIDTH + AXIS_TDATA_WIDTH;

  logic [CNTR_WIDTH-1:0]       ts_q, ts_d;
  logic [AXIS_TDATA_WIDTH-1:0] prev_q, prev_d;
  logic                        primed_q, primed_d;
  logic                        ev_vld_q, ev_vld_d;
  logic [EW-1:0]               ev_dat_q, ev_dat_d;
  logic [LOST_WIDTH-1:0]       lost_q, lost_d;

  logic                        edge_hit;
  logic                        ev_fire;
  logic                        fifo_full, fifo_empty, fifo_rd, drop;

  // Any masked bit transition counts; several bits changing together still make one event.
  assign edge_hit = |((~prev_q & s_axis_tdata & cfg_rise_mask) |
                      ( prev_q & ~s_axis_tdata & cfg_fall_mask));
  assign ev_fire  = s_axis_tvalid & cfg_enable & primed_q & edge_hit;

  assign m_axis_tvalid = ~fifo_empty;
  assign fifo_rd       = m_axis_tvalid & m_axis_tready;
  // The FIFO accepts a write at full when the head is leaving on the same edge.
  assign drop          = ev_vld_q & fifo_full & ~fifo_rd;

  always_comb begin
    ts_d     = ts_q + CNTR_WIDTH'(1);
    prev_d   = prev_q;
    primed_d = primed_q;
    ev_vld_d = ev_fire;
    ev_dat_d = ev_dat_q;
    lost_d   = lost_q;

    if (s_axis_tvalid) prev_d = s_axis_tdata;

    // Disarming forgets history so re-arming never compares against a stale word.
    if (!cfg_enable)        primed_d = 1'b0;
    else if (s_axis_tvalid) primed_d = 1'b1;

    // Stamp with the counter value of the cycle in which the beat was sampled.
    if (ev_fire) ev_dat_d = {ts_q, s_axis_tdata};

    if (drop && !(&lost_q)) lost_d = lost_q + LOST_WIDTH'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q     <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      ev_vld_q <= 1'b0;
      ev_dat_q <= '0;
      lost_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      ev_vld_q <= ev_vld_d;
      ev_dat_q <= ev_dat_d;
      lost_q   <= lost_d;
    end
  end

  assign sts_lost = lost_q;

  axis_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (ev_vld_q),
    .wr_data (ev_dat_q),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (m_axis_tdata),
    .empty   (fifo_empty),
    .count   (sts_count)
  );

endmodule

// File: tb/tb_axis_gpio_event_stamper.sv
// Purpose : self-checking bench for axis_gpio_event_stamper with a queue-based reference model.
// Latency : checks every output 1 time unit after each rising clock edge.
// Backpressure: drives m_axis_tready from directed steps and random phases.
module tb_axis_gpio_event_stamper;

  localparam int DW    = 32;
  localparam int TW    = 32;
  localparam int DEPTH = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [DW-1:0] cfg_rise_mask = '0;
  logic [DW-1:0] cfg_fall_mask = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [TW+DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [4:0]    sts_count;
  logic [15:0]   sts_lost;

  always #5 aclk = ~aclk;

  axis_gpio_event_stamper dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enable    (cfg_enable),
    .cfg_rise_mask (cfg_rise_mask),
    .cfg_fall_mask (cfg_fall_mask),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_count     (sts_count),
    .sts_lost      (sts_lost)
  );

  // Reference model: events wait in pq until the edge they reach the FIFO, mq is the FIFO contents.
  typedef struct { int due; logic [63:0] dat; } pend_t;
  pend_t       pq[$];
  logic [63:0] mq[$];
  int          edge_n;
  logic [31:0] ts_m;
  logic [31:0] prev_m;
  bit          primed_m;
  int          lost_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    mq.delete();
    edge_n   = 0;
    ts_m     = 0;
    prev_m   = 0;
    primed_m = 0;
    lost_m   = 0;
  endtask

  function automatic bit is_edge(input logic [31:0] p, input logic [31:0] c,
                                 input logic [31:0] rm, input logic [31:0] fm);
    for (int i = 0; i < 32; i++) begin
      if (p[i] == 1'b0 && c[i] == 1'b1 && rm[i]) return 1'b1;
      if (p[i] == 1'b1 && c[i] == 1'b0 && fm[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: apply inputs, advance the model across the edge, compare all outputs.
  task automatic cyc(input logic [31:0] d, input logic v, input logic r);
    pend_t e;
    s_axis_tdata  = d;
    s_axis_tvalid = v;
    m_axis_tready = r;
    @(posedge aclk);
    edge_n++;
    if (mq.size() > 0 && r) void'(mq.pop_front());
    if (pq.size() > 0 && pq[0].due == edge_n) begin
      e = pq.pop_front();
      if (mq.size() < DEPTH) mq.push_back(e.dat);
      else if (lost_m < 65535) lost_m++;
    end
    if (!cfg_enable) primed_m = 0;
    else if (v) begin
      if (primed_m && is_edge(prev_m, d, cfg_rise_mask, cfg_fall_mask))
        pq.push_back('{due: edge_n + 1, dat: {ts_m, d}});
      primed_m = 1;
    end
    if (v) prev_m = d;
    ts_m++;
    #1;
    chk("tvalid", {63'd0, m_axis_tvalid}, {63'd0, mq.size() > 0});
    if (mq.size() > 0) chk("tdata", m_axis_tdata, mq[0]);
    chk("count", {59'd0, sts_count}, 64'(mq.size()));
    chk("lost", {48'd0, sts_lost}, 64'(lost_m));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_count", {59'd0, sts_count}, 64'd0);
    chk("rst_lost", {48'd0, sts_lost}, 64'd0);
    @(posedge aclk);
    @(posedge aclk);
    #3;
    aresetn = 1'b1;
    model_clear();
  endtask

  logic [31:0] t0, tprev, tcur, cur_d;

  initial begin
    model_clear();
    #2;
    do_reset();

    // No events on a constant stream.
    cfg_enable = 1; cfg_rise_mask = 32'h1; cfg_fall_mask = 32'h0;
    for (int i = 0; i < 5; i++) cyc(32'h0, 1, 1);
    chk("quiet_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("quiet_count", {59'd0, sts_count}, 64'd0);

    // Single rising edge: beat {T,1} two clocks later.
    t0 = ts_m;
    cyc(32'h1, 1, 1);
    cyc(32'h1, 1, 1);
    chk("rise_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("rise_beat", m_axis_tdata, {t0, 32'h1});
    cyc(32'h1, 0, 1);

    // Falling edge on bit 31.
    cfg_rise_mask = 0; cfg_fall_mask = 32'h8000_0000;
    cyc(32'h8000_0000, 1, 1);
    cyc(32'h0, 1, 1);
    cyc(32'h0, 0, 1);
    chk("fall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("fall_data", {32'd0, m_axis_tdata[31:0]}, 64'd0);
    cyc(32'h0, 0, 1);

    // Same transition with the fall mask cleared.
    cfg_fall_mask = 0;
    cyc(32'h8000_0000, 1, 1);
    cyc(32'h0, 1, 1);
    cyc(32'h0, 0, 1);
    chk("nofall_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    cyc(32'h0, 0, 1);

    // 20 edges into a stalled FIFO: 16 held, 4 lost, then drain in order.
    cfg_rise_mask = 32'h1; cfg_fall_mask = 32'h1;
    t0 = ts_m;
    for (int i = 0; i < 20; i++) cyc((i % 2 == 0) ? 32'h1 : 32'h0, 1, 0);
    cyc(32'h0, 0, 0);
    cyc(32'h0, 0, 0);
    chk("ovf_count", {59'd0, sts_count}, 64'd16);
    chk("ovf_lost", {48'd0, sts_lost}, 64'd4);
    chk("drain_first", {32'd0, m_axis_tdata[63:32]}, {32'd0, t0});
    tprev = m_axis_tdata[63:32];
    cyc(32'h0, 0, 1);
    for (int i = 1; i < 16; i++) begin
      tcur = m_axis_tdata[63:32];
      chk("drain_ts_step", {32'd0, tcur}, {32'd0, tprev + 32'd1});
      tprev = tcur;
      cyc(32'h0, 0, 1);
    end
    chk("drained", {59'd0, sts_count}, 64'd0);

    // FIFO full while a read and a write land on the same edge.
    for (int i = 0; i < 17; i++) cyc((i % 2 == 0) ? 32'h1 : 32'h0, 1, 0);
    chk("full_count", {59'd0, sts_count}, 64'd16);
    cyc(32'h1, 0, 1);
    chk("full_rw_count", {59'd0, sts_count}, 64'd16);
    chk("full_rw_lost", {48'd0, sts_lost}, 64'd4);
    for (int i = 0; i < 18; i++) cyc(32'h1, 0, 1);
    chk("full_drained", {59'd0, sts_count}, 64'd0);

    // Randomized traffic with occasional disarm and mask changes.
    cur_d = 32'h1;
    for (int seg = 0; seg < 8; seg++) begin
      cfg_rise_mask = $urandom;
      cfg_fall_mask = (seg == 3) ? 32'h0 : $urandom;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 31) == 0) cfg_enable = ~cfg_enable;
        if ($urandom_range(0, 3) == 0) cur_d = $urandom;
        else cur_d = cur_d ^ (32'h1 << $urandom_range(0, 31));
        cyc(cur_d, ($urandom_range(0, 3) != 0), (seg % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                                 : ($urandom_range(0, 3) != 0));
      end
    end
    cfg_enable = 1;

    // Reset while events are queued.
    for (int i = 0; i < 25; i++) cyc(cur_d, 0, 1);
    cfg_rise_mask = 32'h1; cfg_fall_mask = 32'h1;
    cyc(32'h0, 1, 0);
    for (int i = 0; i < 5; i++) cyc((i % 2 == 0) ? 32'h1 : 32'h0, 1, 0);
    cyc(32'h0, 0, 0);
    cyc(32'h0, 0, 0);
    chk("pre_rst_count", {59'd0, sts_count}, 64'd5);
    do_reset();

    // Timestamp restarts at 0: the second beat after reset is stamped 1.
    cyc(32'h0, 1, 0);
    cyc(32'h1, 1, 0);
    cyc(32'h1, 0, 0);
    chk("post_rst_beat", m_axis_tdata, {32'd1, 32'h1});
    cyc(32'h1, 0, 1);
    cyc(32'h1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
